// File: rtl/imm_encoder.sv
// Scatters a sign-extended immediate into an RV32 I/S/B/J instruction over InstrBase, flagging unrepresentable values.
// Latency 2 clk (S1 input reg + range check, S2 pack/output reg); 1 beat/clk; InReady falls only when both stages are stalled.
module imm_encoder #(
  parameter int Width     = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [1:0]           ImmSrc,
  input  logic [Width-1:0]     ImmExt,
  input  logic [31:0]          InstrBase,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [31:0]          Instr,
  output logic                 RangeErr,
  output logic [ERR_CNT_W-1:0] ErrCount
);

  localparam logic [1:0] SRC_I = 2'b00;
  localparam logic [1:0] SRC_S = 2'b01;
  localparam logic [1:0] SRC_B = 2'b10;

  logic                 s1_vld_q, s1_vld_d;
  logic [1:0]           s1_src_q;
  logic [20:0]          s1_imm_q;
  logic [31:0]          s1_base_q;
  logic                 s1_err_q, s1_err_d;
  logic                 s2_vld_q, s2_vld_d;
  logic [31:0]          instr_q, instr_d;
  logic                 rerr_q;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic s2_advance, in_fire, s1_move, out_fire;
  logic top_eq_11, top_eq_12, top_eq_20;

  assign s2_advance = !s2_vld_q || OutReady;
  assign InReady    = !s1_vld_q || s2_advance;
  assign in_fire    = InValid && InReady;
  assign s1_move    = s1_vld_q && s2_advance;
  assign out_fire   = s2_vld_q && OutReady;

  // Upper bits must all be copies of the format's sign bit.
  assign top_eq_11 = (&ImmExt[31:11]) || !(|ImmExt[31:11]);
  assign top_eq_12 = (&ImmExt[31:12]) || !(|ImmExt[31:12]);
  assign top_eq_20 = (&ImmExt[31:20]) || !(|ImmExt[31:20]);

  always_comb begin
    s1_err_d = 1'b0;
    case (ImmSrc)
      SRC_I, SRC_S: s1_err_d = !top_eq_11;
      SRC_B:        s1_err_d = !top_eq_12 || ImmExt[0];
      default:      s1_err_d = !top_eq_20 || ImmExt[0];
    endcase
  end

  always_comb begin
    s1_vld_d = s1_vld_q;
    if (in_fire)      s1_vld_d = 1'b1;
    else if (s1_move) s1_vld_d = 1'b0;
  end

  always_comb begin
    instr_d = s1_base_q;
    case (s1_src_q)
      SRC_I: instr_d[31:20] = s1_imm_q[11:0];
      SRC_S: begin
        instr_d[31:25] = s1_imm_q[11:5];
        instr_d[11:7]  = s1_imm_q[4:0];
      end
      SRC_B: begin
        instr_d[31]    = s1_imm_q[12];
        instr_d[30:25] = s1_imm_q[10:5];
        instr_d[11:8]  = s1_imm_q[4:1];
        instr_d[7]     = s1_imm_q[11];
      end
      default: begin
        instr_d[31]    = s1_imm_q[20];
        instr_d[30:21] = s1_imm_q[10:1];
        instr_d[20]    = s1_imm_q[11];
        instr_d[19:12] = s1_imm_q[19:12];
      end
    endcase
  end

  always_comb begin
    s2_vld_d = s2_vld_q;
    if (s2_advance) s2_vld_d = s1_vld_q;
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_fire && rerr_q && (err_cnt_q != {ERR_CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q  <= 1'b0;
      s1_src_q  <= 2'b00;
      s1_imm_q  <= '0;
      s1_base_q <= '0;
      s1_err_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      instr_q   <= '0;
      rerr_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s2_vld_q  <= s2_vld_d;
      err_cnt_q <= err_cnt_d;
      if (in_fire) begin
        s1_src_q  <= ImmSrc;
        s1_imm_q  <= ImmExt[20:0];
        s1_base_q <= InstrBase;
        s1_err_q  <= s1_err_d;
      end
      if (s1_move) begin
        instr_q <= instr_d;
        rerr_q  <= s1_err_q;
      end
    end
  end

  assign OutValid = s2_vld_q;
  assign Instr    = instr_q;
  assign RangeErr = rerr_q;
  assign ErrCount = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and random checks of imm_encoder: latency, packing, range flags, backpressure, reset and round trip.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [1:0]  ImmSrc = 2'b00;
  logic [31:0] ImmExt = '0;
  logic [31:0] InstrBase = '0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [31:0] Instr;
  logic        RangeErr;
  logic [7:0]  ErrCount;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
    logic        err;
  } beat_t;

  imm_encoder #(.Width(32), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(InReady),
    .ImmSrc(ImmSrc), .ImmExt(ImmExt), .InstrBase(InstrBase),
    .OutValid(OutValid), .OutReady(OutReady), .Instr(Instr),
    .RangeErr(RangeErr), .ErrCount(ErrCount)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] imm, input logic [31:0] base);
    InValid = v; ImmSrc = s; ImmExt = imm; InstrBase = base;
  endtask

  function automatic logic [31:0] extend(input logic [1:0] s, input logic [31:0] i);
    case (s)
      2'b00:   return {{20{i[31]}}, i[31:20]};
      2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
      2'b10:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] imm_mask(input logic [1:0] s);
    case (s)
      2'b00:   return 32'hFFF0_0000;
      2'b01,
      2'b10:   return 32'hFE00_0F80;
      default: return 32'hFFFF_F000;
    endcase
  endfunction

  function automatic logic model_err(input logic [1:0] s, input logic [31:0] imm);
    longint v;
    v = longint'($signed(imm));
    case (s)
      2'b00, 2'b01: return (v < -2048) || (v > 2047);
      2'b10:        return (v < -4096) || (v > 4095) || imm[0];
      default:      return (v < -(64'sd1 << 20)) || (v > (64'sd1 << 20) - 1) || imm[0];
    endcase
  endfunction

  task automatic test_reset();
    #2;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got=%b want=0", OutValid); end
    checks++; if (Instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h want=00000000", Instr); end
    checks++; if (RangeErr !== 1'b0) begin errors++; $display("FAIL reset_rangeerr got=%b want=0", RangeErr); end
    checks++; if (ErrCount !== 8'd0) begin errors++; $display("FAIL reset_errcount got=%0d want=0", ErrCount); end
    step(); step();
    reset_n = 1'b1;
    step();
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL post_reset_outvalid got=%b want=0", OutValid); end
  endtask

  task automatic test_i_latency();
    OutReady = 1'b1;
    drive(1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0000_0093);
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL i_inready got=%b want=1", InReady); end
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL i_early_valid got=%b want=0", OutValid); end
    step();
    checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL i_latency got=%b want=1", OutValid); end
    checks++; if (Instr !== 32'hFFF0_0093) begin errors++; $display("FAIL i_instr got=%h want=fff00093", Instr); end
    checks++; if (RangeErr !== 1'b0) begin errors++; $display("FAIL i_rangeerr got=%b want=0", RangeErr); end
    step();
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL i_drain got=%b want=0", OutValid); end
  endtask

  task automatic test_sbj();
    logic [1:0]  s_t [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] i_t [3] = '{32'd8, 32'd16, 32'h800};
    logic [31:0] b_t [3] = '{32'h0000_2023, 32'h0000_0063, 32'h0000_00EF};
    logic [31:0] e_t [3] = '{32'h0000_2423, 32'h0000_0863, 32'h0010_00EF};
    OutReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, s_t[k], i_t[k], b_t[k]);
      step();
      drive(1'b0, 2'b00, 32'h0, 32'h0);
      step();
      checks++; if (OutValid !== 1'b1 || Instr !== e_t[k] || RangeErr !== 1'b0) begin
        errors++; $display("FAIL sbj_%0d got v=%b instr=%h err=%b want v=1 instr=%h err=0", k, OutValid, Instr, RangeErr, e_t[k]);
      end
      step();
    end
  endtask

  task automatic test_range();
    OutReady = 1'b1;
    checks++; if (ErrCount !== 8'd0) begin errors++; $display("FAIL range_cnt0 got=%0d want=0", ErrCount); end
    drive(1'b1, 2'b00, 32'h0000_0800, 32'h0000_0013);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    step();
    checks++; if (OutValid !== 1'b1 || RangeErr !== 1'b1) begin errors++; $display("FAIL range_i_flag got v=%b err=%b want v=1 err=1", OutValid, RangeErr); end
    checks++; if (Instr[31:20] !== 12'h800) begin errors++; $display("FAIL range_i_trunc got=%h want=800", Instr[31:20]); end
    step();
    checks++; if (ErrCount !== 8'd1) begin errors++; $display("FAIL range_cnt1 got=%0d want=1", ErrCount); end
    drive(1'b1, 2'b10, 32'd3, 32'h0000_0063);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    step();
    checks++; if (OutValid !== 1'b1 || RangeErr !== 1'b1) begin errors++; $display("FAIL range_b_flag got v=%b err=%b want v=1 err=1", OutValid, RangeErr); end
    step();
    checks++; if (ErrCount !== 8'd2) begin errors++; $display("FAIL range_cnt2 got=%0d want=2", ErrCount); end
    checks++; if (RangeErr !== 1'b1 || OutValid !== 1'b0) begin errors++; $display("FAIL range_after got v=%b want v=0", OutValid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [3] = '{32'h0010_0013, 32'h0020_0013, 32'h0030_0013};
    int si = 0;
    int ri = 0;
    int c  = 0;
    step();
    while (ri < 3 && c < 40) begin
      if (si < 3) drive(1'b1, 2'b00, si + 1, 32'h0000_0013);
      else        drive(1'b0, 2'b00, 32'h0, 32'h0);
      OutReady = (c >= 7);
      #1;
      if (c == 2) begin
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL bp_inready got=%b want=0", InReady); end
      end
      if (c >= 2 && c <= 6) begin
        checks++; if (OutValid !== 1'b1 || Instr !== exp_q[0]) begin
          errors++; $display("FAIL bp_stable_c%0d got v=%b instr=%h want v=1 instr=%h", c, OutValid, Instr, exp_q[0]);
        end
      end
      if (OutValid && OutReady) begin
        checks++; if (Instr !== exp_q[ri] || RangeErr !== 1'b0) begin
          errors++; $display("FAIL bp_order_%0d got=%h want=%h", ri, Instr, exp_q[ri]);
        end
        ri++;
      end
      if (InValid && InReady) si++;
      step();
      c++;
    end
    checks++; if (ri !== 3) begin errors++; $display("FAIL bp_delivered got=%0d want=3", ri); end
    drive(1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_reset_midflight();
    OutReady = 1'b0;
    drive(1'b1, 2'b00, 32'd5, 32'h0000_0013);
    step();
    drive(1'b1, 2'b00, 32'd6, 32'h0000_0013);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    checks++; if (OutValid !== 1'b1 || ErrCount !== 8'd2) begin errors++; $display("FAIL mid_pre got v=%b cnt=%0d want v=1 cnt=2", OutValid, ErrCount); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got=%b want=0", OutValid); end
    checks++; if (ErrCount !== 8'd0) begin errors++; $display("FAIL mid_errcount got=%0d want=0", ErrCount); end
    step();
    reset_n = 1'b1;
    OutReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL mid_stale_%0d got=%b want=0", k, OutValid); end
    end
    drive(1'b1, 2'b01, 32'hFFFF_FFFF, 32'h0000_0023);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    step();
    checks++; if (OutValid !== 1'b1 || Instr !== 32'hFE00_0FA3) begin errors++; $display("FAIL mid_resume got v=%b instr=%h want v=1 instr=fe000fa3", OutValid, Instr); end
    step();
  endtask

  task automatic test_random();
    beat_t q [$];
    beat_t e;
    logic [31:0] r;
    int sent = 0, recv = 0, cyc = 0, mcnt = 0, nerr = 0;
    logic acc = 1'b1;
    while (recv < 10000 && cyc < 60000) begin
      if (acc || !InValid) begin
        if (sent < 10000) begin
          r = $urandom;
          ImmSrc = 2'($urandom_range(0, 3));
          InstrBase = $urandom;
          case ($urandom_range(0, 3))
            0: ImmExt = $urandom;
            1: ImmExt = {{20{r[11]}}, r[11:0]};
            2: ImmExt = {{19{r[12]}}, r[12:1], 1'b0};
            default: ImmExt = {{11{r[20]}}, r[20:1], 1'b0};
          endcase
          InValid = 1'b1;
        end else begin
          InValid = 1'b0;
        end
      end
      OutReady = ($urandom_range(0, 3) != 0);
      #1;
      if (OutValid && OutReady) begin
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL rnd_extra_beat instr=%h", Instr);
        end else begin
          e = q.pop_front();
          checks++; if (RangeErr !== e.err) begin errors++; $display("FAIL rnd_err src=%0d imm=%h got=%b want=%b", e.src, e.imm, RangeErr, e.err); end
          checks++; if ((Instr & ~imm_mask(e.src)) !== (e.base & ~imm_mask(e.src))) begin
            errors++; $display("FAIL rnd_base got=%h want=%h", Instr & ~imm_mask(e.src), e.base & ~imm_mask(e.src));
          end
          if (!e.err) begin
            checks++; if (extend(e.src, Instr) !== e.imm) begin errors++; $display("FAIL rnd_roundtrip src=%0d got=%h want=%h", e.src, extend(e.src, Instr), e.imm); end
          end
          checks++; if (ErrCount !== 8'(mcnt)) begin errors++; $display("FAIL rnd_errcount got=%0d want=%0d", ErrCount, mcnt); end
          if (e.err) begin
            nerr++;
            if (mcnt < 255) mcnt++;
          end
        end
        recv++;
      end
      acc = InValid && InReady;
      if (acc) begin
        e.src = ImmSrc; e.imm = ImmExt; e.base = InstrBase; e.err = model_err(ImmSrc, ImmExt);
        q.push_back(e);
        sent++;
      end
      step();
      cyc++;
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    checks++; if (recv !== 10000) begin errors++; $display("FAIL rnd_timeout got=%0d want=10000", recv); end
    checks++; if (nerr < 255 || ErrCount !== 8'd255) begin errors++; $display("FAIL rnd_saturate got=%0d want=255 (errors=%0d)", ErrCount, nerr); end
  endtask

  initial begin
    test_reset();
    test_i_latency();
    test_sbj();
    test_range();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
